// File: rtl/seq_timing_ctrl.sv
// seq_timing_ctrl: sequence counter, run/halt flip-flop, single-step gating and retired-instruction count
module seq_timing_ctrl #(
   parameter int SC_W   = 4,
   parameter int ICNT_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              halt,
   input  logic              sc_clr,
   input  logic              step_en,
   input  logic              step_req,
   input  logic              err_clr,
   output logic [SC_W-1:0]   sc_out,
   output logic              running,
   output logic              adv,
   output logic              fetch_start,
   output logic              wrap_err,
   output logic [ICNT_W-1:0] instr_count
);
   typedef enum logic {STOPPED, RUNNING} run_t;
   run_t              state, state_n;
   logic [SC_W-1:0]   sc_n;
   logic [ICNT_W-1:0] cnt_n;
   logic              step_req_q, step_rise, wrap, err_n, fetch_n;
   assign running   = state == RUNNING;
   assign step_rise = step_req & ~step_req_q;
   assign adv       = running & (~step_en | step_rise);
   always_comb begin
      state_n = state;
      sc_n    = sc_out;
      cnt_n   = instr_count;
      wrap    = 1'b0;
      if (!running) begin
         if (start) begin
            state_n = RUNNING;
            sc_n    = '0;
         end
      end else if (adv) begin
         if (halt) begin
            state_n = STOPPED;
            sc_n    = '0;
            cnt_n   = instr_count + 1'b1;
         end else if (sc_clr) begin
            sc_n  = '0;
            cnt_n = instr_count + 1'b1;
         end else begin
            sc_n = sc_out + 1'b1;
            wrap = &sc_out;
         end
      end
      // a wrap in the same cycle as err_clr must win so the error is not lost
      err_n   = wrap | (wrap_err & ~err_clr);
      fetch_n = (state_n == RUNNING) & (sc_n == '0);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= STOPPED;
         sc_out      <= '0;
         instr_count <= '0;
         wrap_err    <= 1'b0;
         fetch_start <= 1'b0;
         step_req_q  <= 1'b0;
      end else begin
         state       <= state_n;
         sc_out      <= sc_n;
         instr_count <= cnt_n;
         wrap_err    <= err_n;
         fetch_start <= fetch_n;
         step_req_q  <= step_req;
      end
   end
endmodule

// File: tb/tb_seq_timing_ctrl.sv
// tb_seq_timing_ctrl: vector table, multi-cycle corner sequences and a randomized run against a reference model
module tb_seq_timing_ctrl;
   logic        clk = 1'b0;
   logic        rst_n, start, halt, sc_clr, step_en, step_req, err_clr;
   logic [3:0]  sc_out;
   logic        running, adv, fetch_start, wrap_err;
   logic [15:0] instr_count;
   int total = 0;
   int bad   = 0;
   always #5 clk = ~clk;
   seq_timing_ctrl #(.SC_W(4), .ICNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .halt(halt), .sc_clr(sc_clr),
      .step_en(step_en), .step_req(step_req), .err_clr(err_clr),
      .sc_out(sc_out), .running(running), .adv(adv), .fetch_start(fetch_start),
      .wrap_err(wrap_err), .instr_count(instr_count)
   );
   typedef struct {
      logic [5:0] in;
      int sc, run, fs, err, cnt;
   } vec_t;
   vec_t vecs[16];
   int m_run, m_sc, m_cnt, m_err, m_fs, m_prev, m_adv;
   task automatic check(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask
   task automatic check_all(input string nm, input int sc, input int run, input int fs, input int err, input int cnt);
      check({nm, " sc_out"}, int'(sc_out), sc);
      check({nm, " running"}, int'(running), run);
      check({nm, " fetch_start"}, int'(fetch_start), fs);
      check({nm, " wrap_err"}, int'(wrap_err), err);
      check({nm, " instr_count"}, int'(instr_count), cnt);
   endtask
   task automatic idle_inputs();
      {start, halt, sc_clr, step_en, step_req, err_clr} = 6'b0;
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic do_reset();
      rst_n = 1'b0;
      idle_inputs();
      tick();
      rst_n = 1'b1;
      m_run = 0; m_sc = 0; m_cnt = 0; m_err = 0; m_fs = 0; m_prev = 0;
   endtask
   // model evaluated on values sampled just before the rising edge
   function automatic int model_adv();
      return int'(m_run != 0 && (!step_en || (step_req && m_prev == 0)));
   endfunction
   task automatic model_step();
      int set;
      set = 0;
      if (m_run == 0) begin
         if (start) begin m_run = 1; m_sc = 0; end
      end else if (model_adv() != 0) begin
         if (halt) begin
            m_run = 0; m_sc = 0; m_cnt = (m_cnt + 1) % 65536;
         end else if (sc_clr) begin
            m_sc = 0; m_cnt = (m_cnt + 1) % 65536;
         end else begin
            set  = int'(m_sc == 15);
            m_sc = (m_sc + 1) % 16;
         end
      end
      m_err  = int'(set != 0 || (m_err != 0 && !err_clr));
      m_prev = int'(step_req);
      m_fs   = int'(m_run != 0 && m_sc == 0);
   endtask
   initial begin
      int adv_cnt;
      // {start, halt, sc_clr, step_en, step_req, err_clr} -> sc, run, fs, err, cnt
      vecs[0]  = '{6'b100000, 0, 1, 1, 0, 0};
      vecs[1]  = '{6'b000000, 1, 1, 0, 0, 0};
      vecs[2]  = '{6'b000000, 2, 1, 0, 0, 0};
      vecs[3]  = '{6'b000000, 3, 1, 0, 0, 0};
      vecs[4]  = '{6'b000000, 4, 1, 0, 0, 0};
      vecs[5]  = '{6'b000000, 5, 1, 0, 0, 0};
      vecs[6]  = '{6'b001000, 0, 1, 1, 0, 1};
      vecs[7]  = '{6'b011000, 0, 0, 0, 0, 2};
      vecs[8]  = '{6'b000000, 0, 0, 0, 0, 2};
      vecs[9]  = '{6'b110000, 0, 1, 1, 0, 2};
      vecs[10] = '{6'b000100, 0, 1, 1, 0, 2};
      vecs[11] = '{6'b000110, 1, 1, 0, 0, 2};
      vecs[12] = '{6'b000110, 1, 1, 0, 0, 2};
      vecs[13] = '{6'b010100, 1, 1, 0, 0, 2};
      vecs[14] = '{6'b000110, 2, 1, 0, 0, 2};
      vecs[15] = '{6'b000000, 3, 1, 0, 0, 2};
      rst_n = 1'b0;
      idle_inputs();
      #1;
      check_all("reset", 0, 0, 0, 0, 0);
      tick();
      do_reset();
      for (int i = 0; i < 16; i++) begin
         {start, halt, sc_clr, step_en, step_req, err_clr} = vecs[i].in;
         tick();
         check_all($sformatf("vec%0d", i), vecs[i].sc, vecs[i].run, vecs[i].fs, vecs[i].err, vecs[i].cnt);
      end
      // wrap without sc_clr, sticky error, and set-vs-clear collision
      do_reset();
      start = 1'b1; tick(); start = 1'b0;
      for (int i = 0; i < 15; i++) tick();
      check_all("pre_wrap", 15, 1, 0, 0, 0);
      tick();
      check_all("wrap", 0, 1, 1, 1, 0);
      for (int i = 0; i < 3; i++) tick();
      check("wrap_sticky", int'(wrap_err), 1);
      err_clr = 1'b1; tick(); err_clr = 1'b0;
      check("err_cleared", int'(wrap_err), 0);
      for (int i = 0; i < 11; i++) tick();
      check("sc_at_15_again", int'(sc_out), 15);
      err_clr = 1'b1; tick(); err_clr = 1'b0;
      check("set_wins_over_clr", int'(wrap_err), 1);
      // single-step with a held button
      do_reset();
      start = 1'b1; tick(); start = 1'b0;
      step_en = 1'b1;
      adv_cnt = 0;
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 12; i++) begin
            step_req = (i < 10);
            #2;
            if (adv) adv_cnt++;
            tick();
         end
      end
      check("step_sc", int'(sc_out), 3);
      check("step_adv_cycles", adv_cnt, 3);
      // halt and sc_clr together retire exactly one instruction
      step_en = 1'b0; halt = 1'b1; sc_clr = 1'b1; tick(); halt = 1'b0; sc_clr = 1'b0;
      check_all("halt_clr", 0, 0, 0, 0, 1);
      for (int i = 0; i < 5; i++) tick();
      check_all("halted_hold", 0, 0, 0, 0, 1);
      start = 1'b1; tick(); start = 1'b0;
      check_all("resume", 0, 1, 1, 0, 1);
      tick();
      check("resume_adv", int'(sc_out), 1);
      // asynchronous reset mid-instruction
      do_reset();
      start = 1'b1; tick(); start = 1'b0;
      for (int i = 0; i < 7; i++) tick();
      check("pre_async_sc", int'(sc_out), 7);
      #1 rst_n = 1'b0;
      #1;
      check_all("async_reset", 0, 0, 0, 0, 0);
      tick();
      rst_n = 1'b1;
      m_run = 0; m_sc = 0; m_cnt = 0; m_err = 0; m_fs = 0; m_prev = 0;
      // randomized run against the model
      for (int c = 0; c < 3000; c++) begin
         start    = ($urandom_range(0, 7) == 0);
         halt     = ($urandom_range(0, 15) == 0);
         sc_clr   = ($urandom_range(0, 5) == 0);
         err_clr  = ($urandom_range(0, 15) == 0);
         step_req = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 19) == 0) step_en = ~step_en;
         #2;
         m_adv = model_adv();
         check($sformatf("rnd%0d adv", c), int'(adv), m_adv);
         @(posedge clk);
         model_step();
         #1;
         check_all($sformatf("rnd%0d", c), m_sc, m_run, m_fs, m_err, m_cnt);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
